pixel_combinator: RTL
=====================

# pixel_combinator

Downstream consumer of the per-engine pixel queues. It walks the frame in raster order and broadcasts the next expected coordinate to every queue. When a queue's head matches, that queue pops itself; this block then captures the queue's colour and emits it as one beat of a valid/ready pixel stream toward the video output. It is the only point where out-of-order engine results are re-serialised into scan order.

## Interface
- NUM_QUEUES, 4, number of engine queues attached
- DATA_WIDTH, 10, coordinate width
- RBG_SIZE, 24, colour width
- IMG_WIDTH, 640, pixels per line; must be < 2^DATA_WIDTH − 1
- IMG_HEIGHT, 480, lines per frame; must be < 2^DATA_WIDTH − 1

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- match_i  in  NUM_QUEUES  per-queue head-matches-check flag (combinational from queue)
- colour_i  in  NUM_QUEUES*RBG_SIZE  per-queue popped colour, queue k at bits [k*RBG_SIZE +: RBG_SIZE]
- xpixel_check  out  DATA_WIDTH  coordinate broadcast to all queues
- ypixel_check  out  DATA_WIDTH  coordinate broadcast to all queues
- out_colour  out  RBG_SIZE  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from sink
- out_sof  out  1  beat is pixel (0,0)
- out_eol  out  1  beat is x = IMG_WIDTH−1
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted
- dup_error  out  1  sticky; more than one match_i bit high in a sampled cycle

## Operation
- Raster counters x_cnt, y_cnt: x increments, wraps IMG_WIDTH−1 → 0 and increments y; y wraps IMG_HEIGHT−1 → 0.
- Parking coordinate is all ones on both check outputs. Queues never hold it, so no pop can occur while parked.
- FSM states:
  - SCAN: check outputs = (x_cnt, y_cnt). If any match_i is set, record the lowest set index as sel, record sof/eol/last flags for the current coordinate, advance the counters, and go to CAPTURE. Otherwise stay in SCAN.
  - CAPTURE: check outputs parked. Load out_colour ← colour_i[sel], out_sof/out_eol from the recorded flags, set out_valid = 1, and go to OUTPUT.
  - OUTPUT: check outputs parked; outputs held stable. On out_valid && out_ready, clear out_valid and go to SCAN. If the accepted beat was the last pixel of the frame, pulse frame_done.
- Multiple match_i bits in SCAN: the lowest index wins and dup_error sets. The other matching queues have also popped, and their data is lost. This is an error condition only, not recovered.
- dup_error clears only on reset.
- Match bits while in CAPTURE or OUTPUT are ignored. They cannot occur legally because coordinates are parked.

## Timing
- Reset values: FSM = SCAN, x_cnt = y_cnt = 0, out_valid = 0, out_colour = 0, out_sof = out_eol = 0, frame_done = 0, dup_error = 0.
- Check outputs in reset cycle = (0,0).
- Latency: match seen in SCAN cycle T → out_valid high from cycle T+2.
- colour_i[sel] is sampled at the edge ending CAPTURE (T+1). The queue's output is stable by then.
- Throughput: at most 1 pixel per 3 cycles with out_ready held high (SCAN, CAPTURE, OUTPUT).
- Handshake: once out_valid is high, out_colour/out_sof/out_eol must not change until accepted. out_valid never drops without acceptance.
- frame_done is high in the cycle after the final beat's acceptance edge, for exactly one cycle.
- Reset mid-frame, in any state: return to reset values next cycle. Any pending beat is discarded.

## Test plan
- Single queue, 4×2 frame, queue pre-loaded with pixels in raster order, out_ready = 1 → 8 beats in order. out_sof on beat 0 only. out_eol on beats 3 and 7. frame_done pulses once after beat 7. Beats spaced 3 cycles.
- Two queues supplying alternate pixels with random delays → output strictly in raster order. Colours match the source queue. dup_error = 0.
- Backpressure: hold out_ready = 0 for 10 cycles during OUTPUT → out_colour stable, check outputs = all ones, no match_i pulses observed.
- Force match_i = 4'b0110 in SCAN → out_colour = colour_i[1], dup_error = 1 and stays 1 until reset.
- Starvation: no match for 50 cycles → stays in SCAN presenting the same coordinate, out_valid = 0.
- Reset asserted while in OUTPUT with out_valid = 1 → next cycle out_valid = 0, check = (0,0), dup_error = 0.

Source files
------------

// File: rtl/pixel_combinator.sv
// pixel_combinator
//   Re-serialises out-of-order engine results into raster scan order. A raster
//   position is broadcast to every engine queue; the queue whose head matches
//   pops itself, and its colour is captured and emitted as one valid/ready beat.
//
// Ports
//   clk, reset      : single clock, synchronous active-high reset
//   match_i         : per-queue "head equals check coordinate" flags
//   colour_i        : per-queue popped colour, queue k at [k*RBG_SIZE +: RBG_SIZE]
//   xpixel_check    : x coordinate broadcast to queues (all ones when parked)
//   ypixel_check    : y coordinate broadcast to queues (all ones when parked)
//   out_colour      : stream data
//   out_valid       : stream valid
//   out_ready       : stream ready from sink
//   out_sof         : beat is pixel (0,0)
//   out_eol         : beat is the last pixel of a line
//   frame_done      : one-cycle pulse after the last pixel of a frame is accepted
//   dup_error       : sticky, more than one queue matched in a scan cycle
module pixel_combinator #(
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned RBG_SIZE   = 24,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_QUEUES-1:0]          match_i,
  input  logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i,
  output logic [DATA_WIDTH-1:0]          xpixel_check,
  output logic [DATA_WIDTH-1:0]          ypixel_check,
  output logic [RBG_SIZE-1:0]            out_colour,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sof,
  output logic                           out_eol,
  output logic                           frame_done,
  output logic                           dup_error
);

  localparam int unsigned SEL_W = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  typedef enum logic [1:0] {
    SCAN,
    CAPTURE,
    OUTPUT
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   x_cnt_q, x_cnt_d;
  logic [DATA_WIDTH-1:0]   y_cnt_q, y_cnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    rec_sof_q, rec_sof_d;
  logic                    rec_eol_q, rec_eol_d;
  logic                    rec_last_q, rec_last_d;
  logic [RBG_SIZE-1:0]     out_colour_q, out_colour_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_sof_q, out_sof_d;
  logic                    out_eol_q, out_eol_d;
  logic                    frame_done_q, frame_done_d;
  logic                    dup_error_q, dup_error_d;

  logic                    any_match;
  logic                    multi_match;
  logic                    found;
  logic [SEL_W-1:0]        sel_lowest;
  logic                    at_x_end;
  logic                    at_y_end;

  // Lowest-index priority pick among the matching queues.
  always_comb begin
    sel_lowest = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      if (match_i[i] && !found) begin
        sel_lowest = SEL_W'(i);
        found      = 1'b1;
      end
    end
  end

  assign any_match   = |match_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_match = (match_i & (match_i - NUM_QUEUES'(1))) != '0;
  assign at_x_end    = (x_cnt_q == DATA_WIDTH'(IMG_WIDTH - 1));
  assign at_y_end    = (y_cnt_q == DATA_WIDTH'(IMG_HEIGHT - 1));

  // Outside SCAN the broadcast coordinate is parked at all ones, a value no
  // queue can hold, so no pop can happen while a beat is in flight.
  assign xpixel_check = (state_q == SCAN) ? x_cnt_q : '1;
  assign ypixel_check = (state_q == SCAN) ? y_cnt_q : '1;

  always_comb begin
    state_d      = state_q;
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    sel_d        = sel_q;
    rec_sof_d    = rec_sof_q;
    rec_eol_d    = rec_eol_q;
    rec_last_d   = rec_last_q;
    out_colour_d = out_colour_q;
    out_valid_d  = out_valid_q;
    out_sof_d    = out_sof_q;
    out_eol_d    = out_eol_q;
    frame_done_d = 1'b0;
    dup_error_d  = dup_error_q;

    unique case (state_q)
      SCAN: begin
        if (any_match) begin
          sel_d      = sel_lowest;
          rec_sof_d  = (x_cnt_q == '0) && (y_cnt_q == '0);
          rec_eol_d  = at_x_end;
          rec_last_d = at_x_end && at_y_end;
          if (multi_match) begin
            dup_error_d = 1'b1;
          end
          if (at_x_end) begin
            x_cnt_d = '0;
            y_cnt_d = at_y_end ? '0 : y_cnt_q + 1'b1;
          end else begin
            x_cnt_d = x_cnt_q + 1'b1;
          end
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        out_colour_d = colour_i[sel_q*RBG_SIZE +: RBG_SIZE];
        out_sof_d    = rec_sof_q;
        out_eol_d    = rec_eol_q;
        out_valid_d  = 1'b1;
        state_d      = OUTPUT;
      end
      OUTPUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d  = 1'b0;
          frame_done_d = rec_last_q;
          state_d      = SCAN;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SCAN;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      sel_q        <= '0;
      rec_sof_q    <= 1'b0;
      rec_eol_q    <= 1'b0;
      rec_last_q   <= 1'b0;
      out_colour_q <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
      dup_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      sel_q        <= sel_d;
      rec_sof_q    <= rec_sof_d;
      rec_eol_q    <= rec_eol_d;
      rec_last_q   <= rec_last_d;
      out_colour_q <= out_colour_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_eol_q    <= out_eol_d;
      frame_done_q <= frame_done_d;
      dup_error_q  <= dup_error_d;
    end
  end

  assign out_colour = out_colour_q;
  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign frame_done = frame_done_q;
  assign dup_error  = dup_error_q;

endmodule
